// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : change_dispense_ctrl                                       |
// | Description : Coin-hopper payout sequencer. Verifies that the inventory  |
// |               can cover a change amount (in 5-rupee units), then pays it |
// |               out one coin at a time, preferring 10-rupee coins. Each    |
// |               coin uses a four-phase req/ack handshake, and each phase   |
// |               is guarded by a timeout. Hopper inventory is tracked and   |
// |               faults are held until cleared.                             |
// |               Optional macro CHG_AUDIT_EN adds the paid_total and        |
// |               pay_count audit outputs.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module change_dispense_ctrl #(
    parameter int CNT_W       = 6,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             chg_valid,
    input  logic [2:0]       chg_amt,
    output logic             chg_ready,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load10,
    input  logic [CNT_W-1:0] load5,
    output logic             hop10_req,
    input  logic             hop10_ack,
    output logic             hop5_req,
    input  logic             hop5_ack,
    output logic [CNT_W-1:0] cnt10,
    output logic [CNT_W-1:0] cnt5,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             exact_only,
`ifdef CHG_AUDIT_EN
    output logic [9:0]       paid_total,
    output logic [7:0]       pay_count,
`endif
    input  logic             clear_fault
);

    localparam int                 c_TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SELECT = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_REL    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [1:0] c_FC_NONE  = 2'b00;
    localparam logic [1:0] c_FC_INV   = 2'b01;
    localparam logic [1:0] c_FC_RISE  = 2'b10;
    localparam logic [1:0] c_FC_FALL  = 2'b11;

    logic [2:0]         r_state;
    logic [2:0]         r_rem;
    logic               r_sel10;
    logic [c_TMO_W-1:0] r_tmo;
    logic [CNT_W-1:0]   r_cnt10;
    logic [CNT_W-1:0]   r_cnt5;
    logic               r_req10;
    logic               r_req5;
    logic               r_done;
    logic [1:0]         r_fault_code;

    logic [CNT_W-1:0]   w_half;
    logic [CNT_W-1:0]   w_use10;
    logic [CNT_W:0]     w_need5;
    logic               w_ack;

    // Inventory check: use as many 10s as available, the remainder must be 5s
    assign w_half  = CNT_W'(r_rem >> 1);
    assign w_use10 = (r_cnt10 < w_half) ? r_cnt10 : w_half;
    assign w_need5 = (CNT_W+1)'(r_rem) - {w_use10, 1'b0};

    // Only the selected hopper's ack is listened to
    assign w_ack = r_sel10 ? hop10_ack : hop5_ack;

    assign chg_ready  = (r_state == S_IDLE);
    assign fault      = (r_state == S_FAULT);
    assign hop10_req  = r_req10;
    assign hop5_req   = r_req5;
    assign cnt10      = r_cnt10;
    assign cnt5       = r_cnt5;
    assign done       = r_done;
    assign fault_code = r_fault_code;
    assign exact_only = (r_cnt5 < CNT_W'(2));

    // Payout sequencer: state, remaining amount, handshake timer and inventory
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_rem        <= 3'd0;
            r_sel10      <= 1'b0;
            r_tmo        <= '0;
            r_cnt10      <= '0;
            r_cnt5       <= '0;
            r_req10      <= 1'b0;
            r_req5       <= 1'b0;
            r_done       <= 1'b0;
            r_fault_code <= c_FC_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A load in the same cycle wins; the request stays pending
                    if (load_en) begin
                        r_cnt10 <= load10;
                        r_cnt5  <= load5;
                    end else if (chg_valid) begin
                        r_rem <= chg_amt;
                        if (chg_amt == 3'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if ({1'b0, r_cnt5} < w_need5) begin
                        r_fault_code <= c_FC_INV;
                        r_state      <= S_FAULT;
                    end else begin
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_rem == 3'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo   <= '0;
                        r_state <= S_REQ;
                        if ((r_rem >= 3'd2) && (r_cnt10 != '0)) begin
                            r_sel10 <= 1'b1;
                            r_req10 <= 1'b1;
                        end else begin
                            r_sel10 <= 1'b0;
                            r_req5  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // An ack arriving on the last allowed cycle still counts
                    if (w_ack) begin
                        r_req10 <= 1'b0;
                        r_req5  <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_REL;
                        if (r_sel10) begin
                            r_cnt10 <= r_cnt10 - CNT_W'(1);
                            r_rem   <= r_rem - 3'd2;
                        end else begin
                            r_cnt5 <= r_cnt5 - CNT_W'(1);
                            r_rem  <= r_rem - 3'd1;
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_req10      <= 1'b0;
                        r_req5       <= 1'b0;
                        r_fault_code <= c_FC_RISE;
                        r_state      <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                S_REL: begin
                    if (!w_ack) begin
                        r_state <= S_SELECT;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_fault_code <= c_FC_FALL;
                        r_state      <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        r_fault_code <= c_FC_NONE;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_req10 <= 1'b0;
                    r_req5  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CHG_AUDIT_EN
    logic [9:0]  r_paid_total;
    logic [7:0]  r_pay_count;
    logic [10:0] w_paid_sum;
    logic        w_coin_paid;

    assign w_coin_paid = (r_state == S_REQ) && w_ack;
    assign w_paid_sum  = {1'b0, r_paid_total} + (r_sel10 ? 11'd10 : 11'd5);
    assign paid_total  = r_paid_total;
    assign pay_count   = r_pay_count;

    // Audit totals: saturating rupee total and wrapping payout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_paid_total <= 10'd0;
            r_pay_count  <= 8'd0;
        end else begin
            if (w_coin_paid) begin
                r_paid_total <= (w_paid_sum > 11'd1023) ? 10'd1023 : w_paid_sum[9:0];
            end
            if (r_done) begin
                r_pay_count <= r_pay_count + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
module tb_change_dispense_ctrl;

    localparam int CNT_W = 6;

    logic             clock;
    logic             reset;
    logic             chg_valid;
    logic [2:0]       chg_amt;
    logic             chg_ready;
    logic             load_en;
    logic [CNT_W-1:0] load10;
    logic [CNT_W-1:0] load5;
    logic             hop10_req;
    logic             hop10_ack;
    logic             hop5_req;
    logic             hop5_ack;
    logic [CNT_W-1:0] cnt10;
    logic [CNT_W-1:0] cnt5;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    logic             exact_only;
    logic             clear_fault;
`ifdef CHG_AUDIT_EN
    logic [9:0]       paid_total;
    logic [7:0]       pay_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int m10     = 0;
    int m5      = 0;
    int sb[$];

    change_dispense_ctrl #(.CNT_W(CNT_W), .ACK_TIMEOUT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .chg_valid   (chg_valid),
        .chg_amt     (chg_amt),
        .chg_ready   (chg_ready),
        .load_en     (load_en),
        .load10      (load10),
        .load5       (load5),
        .hop10_req   (hop10_req),
        .hop10_ack   (hop10_ack),
        .hop5_req    (hop5_req),
        .hop5_ack    (hop5_ack),
        .cnt10       (cnt10),
        .cnt5        (cnt5),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code),
        .exact_only  (exact_only),
`ifdef CHG_AUDIT_EN
        .paid_total  (paid_total),
        .pay_count   (pay_count),
`endif
        .clear_fault (clear_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int a10, input int a5);
        load_en = 1'b1;
        load10  = CNT_W'(a10);
        load5   = CNT_W'(a5);
        tick();
        load_en = 1'b0;
        m10 = a10;
        m5  = a5;
    endtask

    task automatic issue(input logic [2:0] amt);
        chg_valid = 1'b1;
        chg_amt   = amt;
        tick();
        chg_valid = 1'b0;
    endtask

    // Reference payout: 10s first while at least Rs 10 remains, then 5s
    task automatic model_push(input int amt, output bit ok);
        int c10, c5, r, u10;
        c10 = m10; c5 = m5; r = amt;
        u10 = (r / 2 < c10) ? r / 2 : c10;
        if (r - 2 * u10 > c5) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
            while (r > 0) begin
                if (r >= 2 && c10 > 0) begin
                    sb.push_back(10); c10--; r -= 2;
                end else begin
                    sb.push_back(5); c5--; r -= 1;
                end
            end
            m10 = c10;
            m5  = c5;
        end
    endtask

    // Acts as both hoppers with prompt acks and compares every coin to the scoreboard
    task automatic serve(input string tag);
        int guard, got, exp_coin;
        bit fin;
        guard = 0; fin = 1'b0;
        while (!fin && guard < 300) begin
            if (done) begin
                fin = 1'b1;
            end else if (hop10_req || hop5_req) begin
                n_total++;
                if (hop10_req && hop5_req) $display("FAIL %s_onehot: both req high, want one", tag);
                else n_pass++;
                got = hop10_req ? 10 : 5;
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL %s_coin: got %0d want no coin", tag, got);
                end else begin
                    exp_coin = sb.pop_front();
                    if (got !== exp_coin) $display("FAIL %s_coin: got %0d want %0d", tag, got, exp_coin);
                    else n_pass++;
                end
                if (got == 10) hop10_ack = 1'b1; else hop5_ack = 1'b1;
                tick();
                n_total++;
                if ((hop10_req | hop5_req) !== 1'b0) $display("FAIL %s_req_drop: got 1 want 0", tag);
                else n_pass++;
                hop10_ack = 1'b0;
                hop5_ack  = 1'b0;
            end
            if (!fin) begin
                tick();
                guard++;
            end
        end
        n_total++;
        if (!fin) $display("FAIL %s_done_timeout: got no done want done", tag);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0) $display("FAIL %s_done_width: got %b want 0", tag, done);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL %s_leftover: got %0d coins pending want 0", tag, sb.size());
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_reset();
        n_total++; if (chg_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", chg_ready); else n_pass++;
        n_total++; if (cnt10 !== '0) $display("FAIL rst_cnt10: got %0d want 0", cnt10); else n_pass++;
        n_total++; if (cnt5 !== '0) $display("FAIL rst_cnt5: got %0d want 0", cnt5); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_total++; if ({hop10_req, hop5_req} !== 2'b00) $display("FAIL rst_req: got %b want 00", {hop10_req, hop5_req}); else n_pass++;
        n_total++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault); else n_pass++;
        n_total++; if (fault_code !== 2'b00) $display("FAIL rst_code: got %b want 00", fault_code); else n_pass++;
        n_total++; if (exact_only !== 1'b1) $display("FAIL rst_exact: got %b want 1", exact_only); else n_pass++;
    endtask

    task automatic test_pay_mixed();
        bit ok;
        load(3, 3);
        n_total++; if (exact_only !== 1'b0) $display("FAIL mix_exact_loaded: got %b want 0", exact_only); else n_pass++;
        model_push(3, ok);
        issue(3'd3);
        serve("mix");
        n_total++; if (cnt10 !== 6'd2) $display("FAIL mix_cnt10: got %0d want 2", cnt10); else n_pass++;
        n_total++; if (cnt5 !== CNT_W'(m5)) $display("FAIL mix_cnt5: got %0d want %0d", cnt5, m5); else n_pass++;
        n_total++; if (fault !== 1'b0) $display("FAIL mix_fault: got %b want 0", fault); else n_pass++;
    endtask

    task automatic test_insufficient();
        bit ok;
        int reqs;
        load(0, 1);
        model_push(2, ok);
        issue(3'd2);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            if (hop10_req || hop5_req) reqs++;
            tick();
        end
        n_total++; if (reqs !== 0) $display("FAIL ins_req: got %0d req cycles want 0", reqs); else n_pass++;
        n_total++; if (fault !== 1'b1) $display("FAIL ins_fault: got %b want 1", fault); else n_pass++;
        n_total++; if (fault_code !== 2'b01) $display("FAIL ins_code: got %b want 01", fault_code); else n_pass++;
        n_total++; if ({cnt10, cnt5} !== {6'd0, 6'd1}) $display("FAIL ins_counts: got %0d/%0d want 0/1", cnt10, cnt5); else n_pass++;
        n_total++; if (chg_ready !== 1'b0) $display("FAIL ins_ready: got %b want 0", chg_ready); else n_pass++;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        n_total++; if (chg_ready !== 1'b1) $display("FAIL ins_clr_ready: got %b want 1", chg_ready); else n_pass++;
        n_total++; if ({fault, fault_code} !== 3'b000) $display("FAIL ins_clr_fault: got %b want 000", {fault, fault_code}); else n_pass++;
    endtask

    task automatic test_multi_coin();
        bit ok;
        load(1, 4);
        model_push(5, ok);
        issue(3'd5);
        serve("multi");
        n_total++; if ({cnt10, cnt5} !== {6'd0, 6'd1}) $display("FAIL multi_counts: got %0d/%0d want 0/1", cnt10, cnt5); else n_pass++;
        n_total++; if (exact_only !== 1'b1) $display("FAIL multi_exact: got %b want 1", exact_only); else n_pass++;
    endtask

    task automatic test_rise_timeout();
        int g, hi;
        load(2, 2);
        issue(3'd2);
        g = 0;
        while (!hop10_req && g < 10) begin tick(); g++; end
        n_total++; if (hop10_req !== 1'b1) $display("FAIL rise_req: got %b want 1", hop10_req); else n_pass++;
        hi = 0;
        while (hop10_req && hi < 40) begin hi++; tick(); end
        n_total++; if (hi !== 15) $display("FAIL rise_cycles: got %0d want 15", hi); else n_pass++;
        n_total++; if (fault !== 1'b1) $display("FAIL rise_fault: got %b want 1", fault); else n_pass++;
        n_total++; if (fault_code !== 2'b10) $display("FAIL rise_code: got %b want 10", fault_code); else n_pass++;
        n_total++; if ({cnt10, cnt5} !== {6'd2, 6'd2}) $display("FAIL rise_counts: got %0d/%0d want 2/2", cnt10, cnt5); else n_pass++;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
    endtask

    task automatic test_fall_timeout();
        int g, lo;
        issue(3'd1);
        g = 0;
        while (!hop5_req && g < 10) begin tick(); g++; end
        n_total++; if (hop5_req !== 1'b1) $display("FAIL fall_req: got %b want 1", hop5_req); else n_pass++;
        hop5_ack = 1'b1;
        tick();
        lo = 0;
        while (!fault && lo < 40) begin lo++; tick(); end
        hop5_ack = 1'b0;
        n_total++; if (lo !== 15) $display("FAIL fall_cycles: got %0d want 15", lo); else n_pass++;
        n_total++; if (fault_code !== 2'b11) $display("FAIL fall_code: got %b want 11", fault_code); else n_pass++;
        n_total++; if ({cnt10, cnt5} !== {6'd2, 6'd1}) $display("FAIL fall_counts: got %0d/%0d want 2/1", cnt10, cnt5); else n_pass++;
        n_total++; if (hop5_req !== 1'b0) $display("FAIL fall_req_low: got %b want 0", hop5_req); else n_pass++;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
    endtask

    task automatic test_reset_mid();
        int g;
        load(0, 3);
        issue(3'd1);
        g = 0;
        while (!hop5_req && g < 10) begin tick(); g++; end
        n_total++; if (hop5_req !== 1'b1) $display("FAIL arst_req_seen: got %b want 1", hop5_req); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (hop5_req !== 1'b0) $display("FAIL arst_req_drop: got %b want 0", hop5_req); else n_pass++;
        n_total++; if ({cnt10, cnt5} !== {6'd0, 6'd0}) $display("FAIL arst_counts: got %0d/%0d want 0/0", cnt10, cnt5); else n_pass++;
        tick();
        reset = 1'b0;
        m10 = 0; m5 = 0;
        tick();
        n_total++; if (chg_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", chg_ready); else n_pass++;
    endtask

    task automatic test_zero_amount();
        issue(3'd0);
        n_total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
        n_total++; if ({hop10_req, hop5_req} !== 2'b00) $display("FAIL zero_req: got %b want 00", {hop10_req, hop5_req}); else n_pass++;
        tick();
        n_total++; if ({done, chg_ready} !== 2'b01) $display("FAIL zero_after: got done,ready=%b want 01", {done, chg_ready}); else n_pass++;
    endtask

    task automatic test_load_priority();
        bit ok;
        chg_valid = 1'b1;
        chg_amt   = 3'd1;
        load_en   = 1'b1;
        load10    = 6'd0;
        load5     = 6'd2;
        tick();
        load_en = 1'b0;
        n_total++; if (cnt5 !== 6'd2) $display("FAIL prio_load: got %0d want 2", cnt5); else n_pass++;
        n_total++; if (chg_ready !== 1'b1) $display("FAIL prio_pending: got ready %b want 1", chg_ready); else n_pass++;
        tick();
        chg_valid = 1'b0;
        n_total++; if (chg_ready !== 1'b0) $display("FAIL prio_accept: got ready %b want 0", chg_ready); else n_pass++;
        m10 = 0; m5 = 2;
        model_push(1, ok);
        serve("prio");
        n_total++; if (cnt5 !== 6'd1) $display("FAIL prio_cnt5: got %0d want 1", cnt5); else n_pass++;
    endtask

    initial begin
        reset       = 1'b0;
        chg_valid   = 1'b0;
        chg_amt     = 3'd0;
        load_en     = 1'b0;
        load10      = '0;
        load5       = '0;
        hop10_ack   = 1'b0;
        hop5_ack    = 1'b0;
        clear_fault = 1'b0;
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_pay_mixed();
        test_insufficient();
        test_multi_coin();
        test_rise_timeout();
        test_fall_timeout();
        test_reset_mid();
        test_zero_amount();
        test_load_priority();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequences the coin hoppers that pay out change after a vend. The vending FSM hands over a change amount in 5-rupee units. This block checks that the hopper inventory can cover it, then drives the 10-rupee and 5-rupee hoppers one coin at a time over a four-phase req/ack handshake. It tracks hopper inventory and flags faults.

Parameters:
CNT_W, 6, width of each hopper inventory counter (max 63 coins)
ACK_TIMEOUT, 15, cycles allowed for ack to rise, or to fall, before a fault is raised

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
chg_valid  input  1  change request valid
chg_amt  input  3  change amount in 5-rupee units (0..7 = Rs 0..35)
chg_ready  output  1  high in IDLE only
load_en  input  1  inventory load strobe (IDLE only; ignored elsewhere)
load10  input  CNT_W  10-rupee coin count to load
load5  input  CNT_W  5-rupee coin count to load
hop10_req  output  1  request one 10-rupee coin
hop10_ack  input  1  10-rupee hopper acknowledge
hop5_req  output  1  request one 5-rupee coin
hop5_ack  input  1  5-rupee hopper acknowledge
cnt10  output  CNT_W  10-rupee coins remaining
cnt5  output  CNT_W  5-rupee coins remaining
done  output  1  one-cycle pulse when payout completes
fault  output  1  sticky fault flag
fault_code  output  2  00 none, 01 insufficient inventory, 10 ack-rise timeout, 11 ack-fall timeout
exact_only  output  1  combinational; high when cnt5 < 2 (machine cannot guarantee change)
clear_fault  input  1  clears fault; valid only in FAULT

Behaviour:
- Reset values:
  - Registered outputs: all low or zero (state IDLE; cnt10, cnt5, fault_code, done, both req = 0).
  - chg_ready: high once reset deasserts.
  - exact_only: high, since cnt5 = 0.
- IDLE:
  - chg_ready = 1.
  - Accept on chg_valid & chg_ready; latch rem = chg_amt.
  - chg_amt = 0: pulse done on the next cycle, return to IDLE, no hopper activity.
  - Otherwise go to CHECK.
  - load_en in IDLE: cnt10 <= load10, cnt5 <= load5 on the next edge.
  - If chg_valid and load_en are both high in the same cycle, the load takes priority; the request stays pending and is accepted the following cycle.
- CHECK (1 cycle):
  - use10 = min(cnt10, rem>>1).
  - If cnt5 < rem - 2*use10: go to FAULT, code 01. No coin is dispensed and inventory is unchanged.
  - Else go to SELECT.
- SELECT:
  - If rem == 0: go to DONE.
  - Else if rem >= 2 and cnt10 > 0: pick 10.
  - Else pick 5.
  - Go to REQ.
- REQ:
  - Assert the chosen hop*_req; hold it until the matching ack = 1.
  - On ack: deassert req; decrement the chosen count; rem -= 2 for a 10-coin, 1 for a 5-coin; go to REL.
- REL: wait for ack = 0, then go to SELECT.
- Only one hop*_req is ever high at a time. The ack of the unselected hopper is ignored.
- Timeout:
  - A counter resets on entry to REQ and REL and increments each cycle.
  - Reaching ACK_TIMEOUT in REQ: go to FAULT, code 10, req dropped.
  - Reaching ACK_TIMEOUT in REL: go to FAULT, code 11.
  - Coins already paid stay decremented.
- DONE: one-cycle done pulse, then IDLE.
- FAULT:
  - fault = 1, chg_ready = 0, all req low.
  - clear_fault: go to IDLE next cycle; fault and fault_code cleared.
- Counters never wrap below 0; CHECK guarantees this.
- Asynchronous reset at any point, including mid-handshake: req drops immediately, inventory is zeroed, state returns to IDLE.

Optional Feature:
- Macro CHG_AUDIT_EN.
- Defined:
  - Adds output paid_total [9:0], the cumulative rupees dispensed (+10 per 10-coin ack, +5 per 5-coin ack).
  - Saturates at 1023 and is cleared only by reset.
  - Adds output pay_count [7:0], incremented on each done pulse, wraps at 256.
- Undefined: neither port nor register exists; all other behaviour is identical.

Test Plan:
- Load cnt10 = 3, cnt5 = 3; request chg_amt = 3 with prompt acks -> one 10-coin then one 5-coin; cnt10 = 2, cnt5 = 2; done pulses once; fault = 0.
- cnt10 = 0, cnt5 = 1; request chg_amt = 2 -> FAULT, code 01, no req asserted, counts unchanged; clear_fault -> IDLE with chg_ready = 1.
- cnt10 = 1, cnt5 = 4; request chg_amt = 5 -> sequence 10, 5, 5, 5; final counts 0/1; exact_only = 1 afterwards.
- hop10_ack held low 15 cycles after req -> FAULT, code 10 at cycle 15, req low; inventory unchanged.
- Assert reset while hop5_req is high -> req low asynchronously, counts 0, state IDLE, chg_ready high after release.
- chg_amt = 0 -> done pulses the next cycle, no req. Same cycle chg_valid + load_en -> load wins, request accepted one cycle later.
